cr16_alu_pipe: RTL and testbench
================================

Name: cr16_alu_pipe

Overview:
Parametrised, registered successor to the combinational CR16 ALU. It keeps the opcode map 0–13 and the 5-bit status encoding, and generalises the datapath to WIDTH bits. It adds a valid/ready handshake on both input and output and an iterative multi-cycle unsigned multiply on opcode 14. It sits between the decode/register-read stage and writeback, and can stall either side.

Parameters:
WIDTH, 16, datapath width in bits (≥4).
MUL_ENABLE, 1, 1 = opcode 14 executes MULU; 0 = opcode 14 is treated as reserved.

Ports:
I_CLK  in  1  clock; all state changes on its rising edge.
I_RESET  in  1  synchronous, active-high reset.
I_VALID  in  1  operation presented on I_A/I_B/I_OPCODE.
O_READY  out  1  block will accept the presented operation this cycle.
I_A  in  WIDTH  operand A.
I_B  in  WIDTH  operand B; also the shift amount.
I_OPCODE  in  4  operation select.
O_VALID  out  1  O_C/O_STATUS hold a result.
I_READY  in  1  consumer accepts the result this cycle.
O_C  out  WIDTH  result.
O_STATUS  out  5  [0] carry, [1] low, [2] flag (signed overflow), [3] zero, [4] negative.

Behaviour:
- Reset (I_RESET high at an edge): state goes to IDLE; O_VALID, O_C and O_STATUS clear to 0; the multiply counter and accumulator clear. A multiply in progress is abandoned. Reset overrides every other input in that cycle.
- O_READY is combinational: (state==IDLE) && (!O_VALID || I_READY) && !I_RESET.
- An operation is accepted at an edge where I_VALID && O_READY. Operands are captured at that edge, so callers may change them afterwards.
- A result is consumed at an edge where O_VALID && I_READY.
- Output hold: while O_VALID && !I_READY, O_C and O_STATUS stay stable.
- States:
  - IDLE: a single-cycle opcode is accepted → result is registered at the same edge and O_VALID=1 from the next cycle. Latency is 1, throughput is 1 per cycle.
  - IDLE: opcode 14 is accepted with MUL_ENABLE=1 → go to MUL, clear O_VALID, count=0.
  - MUL: one shift-add step per cycle over WIDTH cycles. O_READY=0 throughout. After the WIDTH-th step, return to IDLE with O_VALID=1. The result is visible exactly WIDTH edges after the accept edge.
  - IDLE with no accept and the result consumed → O_VALID=0.
- Arithmetic and status:
  - All flags not listed for an opcode are 0. Zero flag = (O_C==0) for every opcode.
  - 0 ADD: C=A+B mod 2^WIDTH. flag = signed overflow; negative = C[MSB].
  - 1 ADDU: C=A+B. carry = carry out of MSB.
  - 2 ADDC: C=A+B+1. flag = signed overflow; negative = C[MSB].
  - 3 ADDCU: C=A+B+1. carry = carry out of MSB.
  - 4 SUB: C=B−A. flag = signed overflow, i.e. A[MSB]≠B[MSB] && C[MSB]≠B[MSB]; negative = signed B<A.
  - 5 SUBU: C=B−A. carry = low = unsigned B<A.
  - 6 AND, 7 OR, 8 XOR: bitwise. 9 NOT: C=~A, I_B ignored.
  - 10 LSH and 12 ALSH: C=A<<B. 11 RSH: C=A>>B, zero fill. 13 ARSH: C=A>>>B, sign fill.
  - Shift amount is the full unsigned B. B≥WIDTH gives 0, except ARSH, which gives all-ones if A[MSB]=1 and 0 otherwise.
  - 14 MULU: C = low WIDTH bits of A*B (unsigned). carry = 1 iff the high WIDTH bits of the product are nonzero.
  - 15, or 14 with MUL_ENABLE=0: C=0, zero=1, latency 1.
- Simultaneous consume and accept in the same cycle: the new result replaces the old one with no bubble.
- I_VALID while O_READY=0: no effect. The caller holds the operation until it is accepted.

Test Plan:
- WIDTH=16, back-to-back: ADD 0x7FFF+0x0001 then SUBU A=5,B=3 with I_READY=1 → cycle 1 C=0x8000, STATUS=10100; cycle 2 C=0xFFFE, STATUS=00011; one result per cycle.
- Output stall: ADDU 0xFFFF+0x0001 with I_READY=0 for 3 cycles → C=0x0000, STATUS=01001 held stable, O_READY=0; on I_READY=1, O_READY=1 in the same cycle.
- MULU A=0x0100, B=0x0100 → O_READY=0 for 16 cycles; O_VALID rises exactly 16 edges after accept; C=0x0000, STATUS=01001. Then A=3, B=5 → C=15, STATUS=00000.
- Shift boundaries: ARSH A=0x8000, B=20 → C=0xFFFF; RSH same operands → C=0x0000, STATUS=01000; LSH A=1, B=15 → C=0x8000.
- Reset mid-multiply at cycle 5 of a MULU → next cycle O_VALID=0, C=0, STATUS=0, O_READY=1; a following ADD 2+2 returns 4 at latency 1.
- WIDTH=8, MUL_ENABLE=0: SUB A=0x01, B=0x80 → C=0x7F, flag=1, negative=1; opcode 14 → C=0, STATUS=01000, latency 1.

Source files
------------

// File: rtl/cr16_alu_pipe.sv
// CR16 ALU with a result register, valid/ready handshakes on both sides and
// an iterative shift-add unsigned multiply on opcode 14.
module cr16_alu_pipe #(
    parameter int WIDTH      = 16,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    input  logic [3:0]       I_OPCODE,
    output logic             O_VALID,
    input  logic             I_READY,
    output logic [WIDTH-1:0] O_C,
    output logic [4:0]       O_STATUS
);
    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDU  = 4'd1;
    localparam logic [3:0] OP_ADDC  = 4'd2;
    localparam logic [3:0] OP_ADDCU = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SUBU  = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_LSH   = 4'd10;
    localparam logic [3:0] OP_RSH   = 4'd11;
    localparam logic [3:0] OP_ALSH  = 4'd12;
    localparam logic [3:0] OP_ARSH  = 4'd13;
    localparam logic [3:0] OP_MULU  = 4'd14;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               valid_r;
    logic [WIDTH-1:0]   c_r;
    logic [4:0]         status_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [CNT_W-1:0]   count_r;

    logic               ready_s;
    logic               accept_s;
    logic               consume_s;
    logic               start_mul_s;
    logic               mul_last_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH:0]     hi_sum_s;
    logic [2*WIDTH-1:0] prod_step_s;
    logic [WIDTH-1:0]   alu_c_s;
    logic [4:0]         alu_status_s;
    logic [4:0]         mul_status_s;
    logic               carry_s;
    logic               low_s;
    logic               flag_s;
    logic               neg_s;

    assign accept_s    = I_VALID && ready_s;
    assign consume_s   = valid_r && I_READY;
    assign start_mul_s = MUL_ENABLE && (I_OPCODE == OP_MULU);
    assign mul_last_s  = (count_r == LAST_STEP);

    // ADDC/ADDCU differ from ADD/ADDU only by carry-in, which is opcode bit 1.
    assign add_s = {1'b0, I_A} + {1'b0, I_B} + {{WIDTH{1'b0}}, I_OPCODE[1]};
    assign sub_s = {1'b0, I_B} - {1'b0, I_A};

    // Product is {hi, lo} with the multiplier in lo; each step adds A into hi when lo[0] is set, then shifts right.
    assign hi_sum_s    = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, mul_a_r} : {(WIDTH+1){1'b0}});
    assign prod_step_s = {hi_sum_s, prod_r[WIDTH-1:1]};
    assign mul_status_s = {1'b0, (prod_step_s[WIDTH-1:0] == {WIDTH{1'b0}}), 1'b0, 1'b0,
                           |prod_step_s[2*WIDTH-1:WIDTH]};

    assign O_READY  = ready_s;
    assign O_VALID  = valid_r;
    assign O_C      = c_r;
    assign O_STATUS = status_r;

    // State register
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && start_mul_s) begin
                    state_s = ST_MUL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Input-side ready: idle, output slot free or draining, and not in reset
    always_comb begin
        ready_s = (state_r == ST_IDLE) && (!valid_r || I_READY) && !I_RESET;
    end

    // Single-cycle result and status
    always_comb begin
        alu_c_s = {WIDTH{1'b0}};
        carry_s = 1'b0;
        low_s   = 1'b0;
        flag_s  = 1'b0;
        neg_s   = 1'b0;
        case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                alu_c_s = add_s[WIDTH-1:0];
                flag_s  = (I_A[MSB] == I_B[MSB]) && (add_s[MSB] != I_A[MSB]);
                neg_s   = add_s[MSB];
            end
            OP_ADDU, OP_ADDCU: begin
                alu_c_s = add_s[WIDTH-1:0];
                carry_s = add_s[WIDTH];
            end
            OP_SUB: begin
                alu_c_s = sub_s[WIDTH-1:0];
                flag_s  = (I_A[MSB] != I_B[MSB]) && (sub_s[MSB] != I_B[MSB]);
                neg_s   = ($signed(I_B) < $signed(I_A));
            end
            OP_SUBU: begin
                alu_c_s = sub_s[WIDTH-1:0];
                carry_s = sub_s[WIDTH];
                low_s   = sub_s[WIDTH];
            end
            OP_AND:          alu_c_s = I_A & I_B;
            OP_OR:           alu_c_s = I_A | I_B;
            OP_XOR:          alu_c_s = I_A ^ I_B;
            OP_NOT:          alu_c_s = ~I_A;
            OP_LSH, OP_ALSH: alu_c_s = I_A << I_B;
            OP_RSH:          alu_c_s = I_A >> I_B;
            OP_ARSH:         alu_c_s = $signed(I_A) >>> I_B;
            default:         alu_c_s = {WIDTH{1'b0}};
        endcase
        alu_status_s = {neg_s, (alu_c_s == {WIDTH{1'b0}}), flag_s, low_s, carry_s};
    end

    // Result register and multiply datapath
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            valid_r  <= 1'b0;
            c_r      <= {WIDTH{1'b0}};
            status_r <= 5'b00000;
            mul_a_r  <= {WIDTH{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (start_mul_s) begin
                            mul_a_r <= I_A;
                            prod_r  <= {{WIDTH{1'b0}}, I_B};
                            count_r <= {CNT_W{1'b0}};
                            valid_r <= 1'b0;
                        end else begin
                            c_r      <= alu_c_s;
                            status_r <= alu_status_s;
                            valid_r  <= 1'b1;
                        end
                    end else if (consume_s) begin
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                ST_MUL: begin
                    prod_r  <= prod_step_s;
                    count_r <= count_r + CNT_W'(1);
                    if (mul_last_s) begin
                        c_r      <= prod_step_s[WIDTH-1:0];
                        status_r <= mul_status_s;
                        valid_r  <= 1'b1;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr16_alu_pipe.sv
// Directed-vector bench for cr16_alu_pipe: a 16-bit multiply-enabled instance
// and an 8-bit instance with the multiplier disabled.
module tb_cr16_alu_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v16, rdy16, ordy16, ov16;
    logic [15:0] a16, b16, c16;
    logic [3:0]  op16;
    logic [4:0]  st16;
    logic        v8, rdy8, ordy8, ov8;
    logic [7:0]  a8, b8, c8;
    logic [3:0]  op8;
    logic [4:0]  st8;

    int tests_run    = 0;
    int tests_failed = 0;

    cr16_alu_pipe #(.WIDTH(16), .MUL_ENABLE(1'b1)) dut16 (
        .I_CLK(clk), .I_RESET(rst), .I_VALID(v16), .O_READY(ordy16),
        .I_A(a16), .I_B(b16), .I_OPCODE(op16), .O_VALID(ov16),
        .I_READY(rdy16), .O_C(c16), .O_STATUS(st16)
    );

    cr16_alu_pipe #(.WIDTH(8), .MUL_ENABLE(1'b0)) dut8 (
        .I_CLK(clk), .I_RESET(rst), .I_VALID(v8), .O_READY(ordy8),
        .I_A(a8), .I_B(b8), .I_OPCODE(op8), .O_VALID(ov8),
        .I_READY(rdy8), .O_C(c8), .O_STATUS(st8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        v16 = 1'b0; rdy16 = 1'b1; a16 = 16'h0000; b16 = 16'h0000; op16 = 4'd0;
        v8  = 1'b0; rdy8  = 1'b1; a8  = 8'h00;    b8  = 8'h00;    op8  = 4'd0;
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("reset_valid",  {31'b0, ov16},  32'd0);
        check_eq("reset_c",      {16'b0, c16},   32'h0);
        check_eq("reset_status", {27'b0, st16},  32'h0);
        check_eq("reset_ready",  {31'b0, ordy16}, 32'd1);

        // Back-to-back ADD then SUBU, one result per cycle
        v16 = 1'b1; a16 = 16'h7FFF; b16 = 16'h0001; op16 = 4'd0;
        step();
        a16 = 16'h0005; b16 = 16'h0003; op16 = 4'd5;
        check_eq("add_valid",  {31'b0, ov16}, 32'd1);
        check_eq("add_c",      {16'b0, c16},  32'h8000);
        check_eq("add_status", {27'b0, st16}, 32'b10100);
        check_eq("add_ready",  {31'b0, ordy16}, 32'd1);
        step();
        v16 = 1'b0;
        check_eq("subu_valid",  {31'b0, ov16}, 32'd1);
        check_eq("subu_c",      {16'b0, c16},  32'hFFFE);
        check_eq("subu_status", {27'b0, st16}, 32'b00011);
        step();
        check_eq("drain_valid", {31'b0, ov16}, 32'd0);

        // Output stall holds the result and blocks the input side
        rdy16 = 1'b0;
        v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; op16 = 4'd1;
        step();
        v16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid",  {31'b0, ov16},   32'd1);
            check_eq("stall_c",      {16'b0, c16},    32'h0000);
            check_eq("stall_status", {27'b0, st16},   32'b01001);
            check_eq("stall_ready",  {31'b0, ordy16}, 32'd0);
            step();
        end
        rdy16 = 1'b1;
        #1;
        check_eq("unstall_ready", {31'b0, ordy16}, 32'd1);
        step();
        check_eq("unstall_drain", {31'b0, ov16}, 32'd0);

        // MULU 0x0100*0x0100: busy 16 cycles, high half nonzero
        v16 = 1'b1; a16 = 16'h0100; b16 = 16'h0100; op16 = 4'd14;
        step();
        v16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_eq("mul_busy_valid", {31'b0, ov16},   32'd0);
            check_eq("mul_busy_ready", {31'b0, ordy16}, 32'd0);
            step();
        end
        check_eq("mul1_valid",  {31'b0, ov16}, 32'd1);
        check_eq("mul1_c",      {16'b0, c16},  32'h0000);
        check_eq("mul1_status", {27'b0, st16}, 32'b01001);

        v16 = 1'b1; a16 = 16'h0003; b16 = 16'h0005; op16 = 4'd14;
        step();
        v16 = 1'b0;
        repeat (15) step();
        check_eq("mul2_early", {31'b0, ov16}, 32'd0);
        step();
        check_eq("mul2_valid",  {31'b0, ov16}, 32'd1);
        check_eq("mul2_c",      {16'b0, c16},  32'd15);
        check_eq("mul2_status", {27'b0, st16}, 32'b00000);

        // Shift boundaries
        v16 = 1'b1; a16 = 16'h8000; b16 = 16'd20; op16 = 4'd13;
        step();
        op16 = 4'd11;
        check_eq("arsh_c",      {16'b0, c16},  32'hFFFF);
        check_eq("arsh_status", {27'b0, st16}, 32'b00000);
        step();
        a16 = 16'h0001; b16 = 16'd15; op16 = 4'd10;
        check_eq("rsh_c",      {16'b0, c16},  32'h0000);
        check_eq("rsh_status", {27'b0, st16}, 32'b01000);
        step();
        v16 = 1'b0;
        check_eq("lsh_c", {16'b0, c16}, 32'h8000);
        step();

        // Reset in cycle 5 of a multiply abandons it
        v16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678; op16 = 4'd14;
        step();
        v16 = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("mrst_valid",  {31'b0, ov16},   32'd0);
        check_eq("mrst_c",      {16'b0, c16},    32'h0);
        check_eq("mrst_status", {27'b0, st16},   32'h0);
        check_eq("mrst_ready",  {31'b0, ordy16}, 32'd1);
        v16 = 1'b1; a16 = 16'd2; b16 = 16'd2; op16 = 4'd0;
        step();
        v16 = 1'b0;
        check_eq("post_rst_valid", {31'b0, ov16}, 32'd1);
        check_eq("post_rst_c",     {16'b0, c16},  32'd4);
        check_eq("post_rst_st",    {27'b0, st16}, 32'b00000);

        // 8-bit instance without multiplier
        v8 = 1'b1; a8 = 8'h01; b8 = 8'h80; op8 = 4'd4;
        step();
        a8 = 8'h03; b8 = 8'h05; op8 = 4'd14;
        check_eq("w8_sub_c",      {24'b0, c8},  32'h7F);
        check_eq("w8_sub_status", {27'b0, st8}, 32'b10100);
        check_eq("w8_ready",      {31'b0, ordy8}, 32'd1);
        step();
        v8 = 1'b0;
        check_eq("w8_op14_valid",  {31'b0, ov8}, 32'd1);
        check_eq("w8_op14_c",      {24'b0, c8},  32'h00);
        check_eq("w8_op14_status", {27'b0, st8}, 32'b01000);
        step();
        check_eq("w8_drain", {31'b0, ov8}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
